tiny_cpu_fetch: RTL and testbench

TINY_CPU_FETCH -- requirements
Module: tiny_cpu_fetch

---
 rtl/tiny_cpu_fetch_if.sv | 35 +++
 rtl/tiny_cpu_fetch.sv | 119 +++++++++++
 tb/tb_tiny_cpu_fetch.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/tiny_cpu_fetch_if.sv
// tiny_cpu_fetch_if
//   Bundles the tiny_cpu_fetch side-band and handshake signals.
//   slave  : the fetch block (drives load_ready, instr_*, prog_len, busy)
//   master : whoever loads the program and consumes instructions
//   Load bus   : load_en, load_valid, load_data -> load_ready
//   Run ctrl   : run_en, pc_load, pc_target
//   Instr bus  : instr_valid, instr_data, instr_pc <- instr_ready
//   Status     : prog_len, busy
interface tiny_cpu_fetch_if #(
  parameter int AW = 4
);
  logic          load_en;
  logic          load_valid;
  logic [7:0]    load_data;
  logic          load_ready;
  logic          run_en;
  logic          pc_load;
  logic [AW-1:0] pc_target;
  logic          instr_valid;
  logic [7:0]    instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic [AW:0]   prog_len;
  logic          busy;

  modport slave (
    input  load_en, load_valid, load_data, run_en, pc_load, pc_target, instr_ready,
    output load_ready, instr_valid, instr_data, instr_pc, prog_len, busy
  );

  modport master (
    output load_en, load_valid, load_data, run_en, pc_load, pc_target, instr_ready,
    input  load_ready, instr_valid, instr_data, instr_pc, prog_len, busy
  );
endinterface

// File: rtl/tiny_cpu_fetch.sv
// tiny_cpu_fetch
//   Small program store plus instruction streamer. A program is written
//   byte-by-byte in LOAD, then streamed one byte per cycle in RUN with a
//   valid/ready handshake and branch (pc_load) support.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : tiny_cpu_fetch_if.slave (load bus, run control, instr bus, status)
module tiny_cpu_fetch #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  tiny_cpu_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   prog_len_q;
  logic          instr_valid_q;
  logic [7:0]    instr_data_q;
  logic [AW-1:0] instr_pc_q;

  // Program memory is deliberately not reset; prog_len gates its use.
  logic [7:0]    mem [DEPTH];

  logic          xfer;
  logic [AW:0]   pc_inc;
  logic [AW-1:0] pc_next_d;

  assign xfer = (state_q == S_LOAD) && bus.load_valid;

  // Wrap to 0 only on exact equality with prog_len; a branch past the end
  // of the program keeps counting up to the top of memory first.
  assign pc_inc    = {1'b0, pc_q} + (AW+1)'(1);
  assign pc_next_d = (pc_inc == prog_len_q) ? '0 : pc_inc[AW-1:0];

  always_ff @(posedge clk) begin
    if (xfer) mem[wr_ptr_q] <= bus.load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
      instr_pc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.load_en) begin
            state_q    <= S_LOAD;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            pc_q       <= '0;
          end else if (bus.run_en && (prog_len_q != '0)) begin
            state_q <= S_RUN;
          end
        end
        S_LOAD: begin
          // A byte presented on the exit edge is still accepted: load_ready
          // reflects the current state, not load_en.
          if (xfer) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (prog_len_q != LEN_MAX) prog_len_q <= prog_len_q + (AW+1)'(1);
          end
          if (!bus.load_en) state_q <= S_IDLE;
        end
        S_RUN: begin
          if (bus.load_en) begin
            state_q       <= S_LOAD;
            wr_ptr_q      <= '0;
            prog_len_q    <= '0;
            pc_q          <= '0;
            instr_valid_q <= 1'b0;
          end else if (!bus.run_en) begin
            // pc is kept so the next RUN resumes where this one stopped.
            state_q       <= S_IDLE;
            instr_valid_q <= 1'b0;
          end else if (bus.pc_load) begin
            // Branch wins over any handshake; the in-flight byte is dropped.
            pc_q          <= bus.pc_target;
            instr_valid_q <= 1'b0;
          end else if (!instr_valid_q || bus.instr_ready) begin
            instr_data_q  <= mem[pc_q];
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= pc_next_d;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready  = (state_q == S_LOAD);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_data  = instr_data_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.prog_len    = prog_len_q;

endmodule

// File: tb/tb_tiny_cpu_fetch.sv
module tb_tiny_cpu_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tiny_cpu_fetch_if #(.AW(4)) b();

  tiny_cpu_fetch #(.DEPTH(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_loading = 0, m_running = 0;
  int         m_len = 0, m_wp = 0, m_pc = 0, m_ipc = 0;
  logic [7:0] m_mem [16];
  logic [7:0] m_d = 8'h00;
  bit         m_v = 0;

  task automatic model_reset();
    m_loading = 0; m_running = 0;
    m_len = 0; m_wp = 0; m_pc = 0; m_ipc = 0; m_d = 8'h00; m_v = 0;
  endtask

  task automatic model_edge();
    bit was_load, was_run;
    was_load = m_loading;
    was_run  = m_running;
    if (was_load && b.load_valid) begin
      m_mem[m_wp] = b.load_data;
      m_wp = (m_wp + 1) % 16;
      if (m_len < 16) m_len++;
    end
    if (b.load_en) begin
      if (!was_load) begin m_wp = 0; m_len = 0; m_pc = 0; end
      m_loading = 1; m_running = 0; m_v = 0;
    end else if (was_load) begin
      m_loading = 0;
    end else if (was_run) begin
      if (!b.run_en) begin
        m_running = 0; m_v = 0;
      end else if (b.pc_load) begin
        m_pc = int'(b.pc_target); m_v = 0;
      end else if (!m_v || b.instr_ready) begin
        m_d = m_mem[m_pc]; m_ipc = m_pc; m_v = 1;
        m_pc = (m_pc + 1 == m_len) ? 0 : (m_pc + 1) % 16;
      end
    end else if (b.run_en && m_len != 0) begin
      m_running = 1;
    end
  endtask

  // Compare process: every edge (clock or async reset), check all outputs.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset(); else model_edge();
    #1;
    chk("m.load_ready",  32'(b.load_ready),  32'(m_loading));
    chk("m.busy",        32'(b.busy),        32'(m_loading || m_running));
    chk("m.prog_len",    32'(b.prog_len),    32'(m_len));
    chk("m.instr_valid", 32'(b.instr_valid), 32'(m_v));
    chk("m.instr_data",  32'(b.instr_data),  32'(m_d));
    chk("m.instr_pc",    32'(b.instr_pc),    32'(m_ipc));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string nm, input bit v, input logic [7:0] d, input logic [3:0] p);
    chk({nm, ".valid"}, 32'(b.instr_valid), 32'(v));
    if (v) begin
      chk({nm, ".data"}, 32'(b.instr_data), 32'(d));
      chk({nm, ".pc"},   32'(b.instr_pc),   32'(p));
    end
  endtask

  task automatic load_bytes(input logic [7:0] first, input int n);
    b.load_en = 1'b1; tick();
    for (int i = 0; i < n; i++) begin
      b.load_valid = 1'b1; b.load_data = first + 8'(i); tick();
    end
    b.load_valid = 1'b0; b.load_en = 1'b0; tick();
  endtask

  initial begin
    b.load_en = 0; b.load_valid = 0; b.load_data = 0; b.run_en = 0;
    b.pc_load = 0; b.pc_target = 0; b.instr_ready = 0;
    tick(3);
    chk("rst.valid", 32'(b.instr_valid), 32'd0);
    chk("rst.busy",  32'(b.busy), 32'd0);
    chk("rst.len",   32'(b.prog_len), 32'd0);
    chk("rst.ready", 32'(b.load_ready), 32'd0);
    rst = 1'b0;

    // run with empty program stays idle
    b.run_en = 1'b1; tick(3);
    chk("empty.busy",  32'(b.busy), 32'd0);
    chk("empty.valid", 32'(b.instr_valid), 32'd0);
    b.run_en = 1'b0; tick();

    // 18 bytes: len saturates, bytes 16/17 overwrite mem[0]/mem[1]
    load_bytes(8'h00, 18);
    chk("l18.len", 32'(b.prog_len), 32'd16);
    b.run_en = 1'b1; b.instr_ready = 1'b1;
    tick(); expect_out("l18.first", 0, 8'h00, 4'd0);
    tick(); expect_out("l18.s0", 1, 8'h10, 4'd0);
    tick(); expect_out("l18.s1", 1, 8'h11, 4'd1);
    tick(); expect_out("l18.s2", 1, 8'h02, 4'd2);
    tick(13); expect_out("l18.s15", 1, 8'h0f, 4'd15);
    tick(); expect_out("l18.wrap", 1, 8'h10, 4'd0);
    b.run_en = 1'b0; b.instr_ready = 1'b0; tick();
    chk("l18.stop.busy", 32'(b.busy), 32'd0);

    // 3-byte program
    b.load_en = 1'b1; tick();
    chk("l3.ready", 32'(b.load_ready), 32'd1);
    chk("l3.clear", 32'(b.prog_len), 32'd0);
    b.load_en = 1'b0; tick(); // back out, then load properly
    load_bytes(8'h11, 0);
    b.load_en = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      b.load_valid = 1'b1; b.load_data = 8'h11 * 8'(i + 1); tick();
    end
    b.load_valid = 1'b0; b.load_en = 1'b0; tick();
    chk("l3.len", 32'(b.prog_len), 32'd3);

    b.run_en = 1'b1; b.instr_ready = 1'b1;
    tick(); expect_out("r.first", 0, 8'h00, 4'd0);
    tick(); expect_out("r.s0", 1, 8'h11, 4'd0);
    tick(); expect_out("r.s1", 1, 8'h22, 4'd1);
    tick(); expect_out("r.s2", 1, 8'h33, 4'd2);
    tick(); expect_out("r.wrap", 1, 8'h11, 4'd0);
    tick(); expect_out("r.s1b", 1, 8'h22, 4'd1);

    // stall three cycles on 0x22
    b.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("stall", 1, 8'h22, 4'd1);
    end
    b.instr_ready = 1'b1;
    tick(); expect_out("stall.rel", 1, 8'h33, 4'd2);

    // branch with simultaneous handshake
    b.pc_load = 1'b1; b.pc_target = 4'd2;
    tick(); expect_out("br.bubble", 0, 8'h00, 4'd0);
    b.pc_load = 1'b0;
    tick(); expect_out("br.tgt", 1, 8'h33, 4'd2);
    tick(); expect_out("br.after", 1, 8'h11, 4'd0);

    // branch beyond prog_len runs to 15 and then wraps to 0
    b.pc_load = 1'b1; b.pc_target = 4'd5;
    tick(); expect_out("far.bubble", 0, 8'h00, 4'd0);
    b.pc_load = 1'b0;
    tick(); expect_out("far.t5", 1, 8'h05, 4'd5);
    tick(10); expect_out("far.t15", 1, 8'h0f, 4'd15);
    tick(); expect_out("far.wrap", 1, 8'h11, 4'd0);

    // RUN->IDLE keeps pc; pc_load in IDLE is ignored
    b.run_en = 1'b0; b.instr_ready = 1'b0; tick();
    chk("idle.busy", 32'(b.busy), 32'd0);
    b.pc_load = 1'b1; b.pc_target = 4'd9; tick();
    b.pc_load = 1'b0; b.run_en = 1'b1; b.instr_ready = 1'b1;
    tick(); expect_out("res.first", 0, 8'h00, 4'd0);
    tick(); expect_out("res.pc1", 1, 8'h22, 4'd1);

    // load_en in RUN: to LOAD, then a 1-byte program repeats pc 0
    b.load_en = 1'b1; tick();
    chk("r2l.ready", 32'(b.load_ready), 32'd1);
    chk("r2l.valid", 32'(b.instr_valid), 32'd0);
    b.load_valid = 1'b1; b.load_data = 8'hAA; tick();
    b.load_valid = 1'b0; b.load_en = 1'b0; tick();
    chk("one.len", 32'(b.prog_len), 32'd1);
    tick(); tick(); expect_out("one.s0", 1, 8'hAA, 4'd0);
    tick(); expect_out("one.s0b", 1, 8'hAA, 4'd0);

    // async reset mid-RUN
    rst = 1'b1; #2;
    chk("arst.valid", 32'(b.instr_valid), 32'd0);
    chk("arst.busy",  32'(b.busy), 32'd0);
    chk("arst.len",   32'(b.prog_len), 32'd0);
    chk("arst.data",  32'(b.instr_data), 32'd0);
    chk("arst.pc",    32'(b.instr_pc), 32'd0);
    tick(); rst = 1'b0; tick(3);
    chk("arst.run.busy",  32'(b.busy), 32'd0);
    chk("arst.run.valid", 32'(b.instr_valid), 32'd0);

    b.run_en = 1'b0; tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
